// File: rtl/drm_metering_event_gen.sv
// Metering event generator: converts per-cycle usage counts into one pulse per
// UNIT units, with a minimum low gap between pulses, a saturating backlog
// counter and a sticky overflow flag for units lost to saturation.
module drm_metering_event_gen #(
    parameter int COUNT_W = 8,
    parameter int UNIT    = 1000,
    parameter int PEND_W  = 16,
    parameter int GAP     = 4
) (
    input  logic                     drm_aclk,
    input  logic                     drm_arstn,
    input  logic                     enable,
    input  logic                     usage_valid,
    input  logic [COUNT_W-1:0]       usage_count,
    input  logic                     clear_overflow,
    output logic                     metering_event,
    output logic [PEND_W-1:0]        pending_count,
    output logic [$clog2(UNIT)-1:0]  residue,
    output logic                     overflow
);

    localparam int RES_W = $clog2(UNIT);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [RES_W:0]   UNIT_W = (RES_W + 1)'(UNIT);
    localparam logic [GAP_W-1:0] GAP_C  = GAP_W'(GAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                evt_q, evt_d;
    logic [RES_W-1:0]    residue_q, residue_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                ovf_q, ovf_d;

    logic [RES_W:0]      add_w;
    logic [RES_W:0]      sum;
    logic [RES_W:0]      diff;
    logic                inc;
    logic                dec;
    logic                lost;

    // Accumulator: one sum a bit wider than residue; UNIT >= 2^COUNT_W means
    // at most one boundary crossing per cycle, so a single subtract suffices.
    always_comb begin
        add_w     = '0;
        if (enable && usage_valid)
            add_w = {{(RES_W + 1 - COUNT_W){1'b0}}, usage_count};
        sum       = {1'b0, residue_q} + add_w;
        diff      = sum - UNIT_W;
        inc       = 1'b0;
        residue_d = sum[RES_W-1:0];
        if (sum >= UNIT_W) begin
            inc       = 1'b1;
            residue_d = diff[RES_W-1:0];
        end
    end

    // Emitter FSM: a pulse is launched from IDLE whenever backlog exists; the
    // gap counter leaves GAP one cycle early so the next rising edge lands
    // exactly 1+GAP cycles after the previous one.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        evt_d   = 1'b0;
        dec     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    state_d = S_PULSE;
                    evt_d   = 1'b1;
                    dec     = 1'b1;
                end
            end
            S_PULSE: begin
                gap_d   = GAP_C;
                state_d = (GAP > 1) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                gap_d = gap_q - 1'b1;
                if ({1'b0, gap_q} <= (GAP_W + 1)'(2))
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Backlog counter with saturation; a unit arriving at full scale is lost.
    always_comb begin
        pend_d = pend_q;
        lost   = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (&pend_q) lost   = 1'b1;
                else         pend_d = pend_q + 1'b1;
            end
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    // Sticky overflow: a new loss takes priority over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (lost)                ovf_d = 1'b1;
        else if (clear_overflow) ovf_d = 1'b0;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            evt_q     <= 1'b0;
            residue_q <= '0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            evt_q     <= evt_d;
            residue_q <= residue_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
        end
    end

    assign metering_event = evt_q;
    assign pending_count  = pend_q;
    assign residue        = residue_q;
    assign overflow       = ovf_q;

endmodule
